// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the GuitarZero sprite ROM fetch path.
package sprite_pkg;

  localparam int SPRITE_ADDR_W = 13;
  localparam int SPRITE_DATA_W = 24;
  localparam int NUM_LANES     = 5;

  typedef enum logic [2:0] {
    LANE_GREEN,
    LANE_RED,
    LANE_YELLOW,
    LANE_BLUE,
    LANE_ORANGE
  } lane_e;

  typedef logic [SPRITE_DATA_W-1:0] rgb_t;

  // Index width for n requesters; never zero so a lone requester still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr wins, wrapping modulo N.
module rr_pick
  import sprite_pkg::*;
#(
  parameter int N     = NUM_LANES,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (enable) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          winner     = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one registered-read sprite ROM among the note lanes,
// with a tag pipeline that steers each returned pixel back to its lane.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_LANES,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int NUM_STG = ROM_LAT + 1;

  typedef struct packed {
    logic               vld;
    logic [NUM_REQ-1:0] lane;
  } tag_t;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] winner;
  tag_t             tag_q [NUM_STG];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .enable (Reset_n & ~stall),
    .grant  (grant),
    .winner (winner)
  );

  // One stage for the address register plus ROM_LAT stages for the ROM itself.
  always_ff @(posedge Clk) begin
    // NOTE: state updates use <= so every register samples pre-edge values, whatever the statement order.
    if (!Reset_n) begin
      rom_addr <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      for (int s = 0; s < NUM_STG; s++) tag_q[s] <= '0;
    end else begin
      if (|grant) begin
        rom_addr <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        ptr_q    <= winner;
      end
      tag_q[0] <= '{vld: |grant, lane: grant};
      for (int s = 1; s < NUM_STG; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < NUM_STG; s++) busy = busy | tag_q[s].vld;
  end

  assign rsp_valid = tag_q[NUM_STG-1].vld ? tag_q[NUM_STG-1].lane : '0;
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed, table-driven bench for sprite_rom_arbiter with a 1-cycle ROM model.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N = 5;
  localparam int AW = 13;

  logic          Clk;
  logic          Reset_n;
  logic          stall;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  grant;
  logic [AW-1:0] rom_addr;
  rgb_t          rom_data;
  logic [N-1:0]  rsp_valid;
  rgb_t          rsp_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] lane_addr [N];

  typedef struct {
    logic         rst_n;
    logic         stall;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] rv;
    logic         busy;
    logic [AW-1:0] ra;
  } vec_t;

  vec_t tbl [$];

  sprite_rom_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (24),
    .ROM_LAT (1)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .stall     (stall),
    .req       (req),
    .req_addr  (req_addr),
    .grant     (grant),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic rgb_t rom_f(input logic [AW-1:0] a);
    if (a == 13'h0A5) return 24'hFF00FF;
    return {3'b101, a, 8'h3C};
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [N-1:0] rq,
                     input logic [N-1:0] g, input logic [N-1:0] rv,
                     input logic b, input logic [AW-1:0] ra);
    vec_t v;
    v.rst_n = r; v.stall = s; v.req = rq; v.grant = g; v.rv = rv; v.busy = b; v.ra = ra;
    tbl.push_back(v);
  endtask

  initial begin
    lane_addr[0] = 13'h100;
    lane_addr[1] = 13'h111;
    lane_addr[2] = 13'h0A5;
    lane_addr[3] = 13'h133;
    lane_addr[4] = 13'h144;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = lane_addr[i];

    //  rst stall req       grant     rsp_valid busy rom_addr
    // all lanes requesting: rotation 0..4,0 then drain
    add(0, 0, 5'b11111, 5'b00000, 5'b00000, 0, 13'h000);
    add(1, 0, 5'b11111, 5'b00001, 5'b00000, 0, 13'h000);
    add(1, 0, 5'b11111, 5'b00010, 5'b00000, 1, 13'h100);
    add(1, 0, 5'b11111, 5'b00100, 5'b00001, 1, 13'h111);
    add(1, 0, 5'b11111, 5'b01000, 5'b00010, 1, 13'h0A5);
    add(1, 0, 5'b11111, 5'b10000, 5'b00100, 1, 13'h133);
    add(1, 0, 5'b11111, 5'b00001, 5'b01000, 1, 13'h144);
    add(1, 0, 5'b00000, 5'b00000, 5'b10000, 1, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00001, 1, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h100);
    // single lane 2 fetch
    add(1, 0, 5'b00100, 5'b00100, 5'b00000, 0, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 13'h0A5);
    add(1, 0, 5'b00000, 5'b00000, 5'b00100, 1, 13'h0A5);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h0A5);
    // pointer wrap: lane 4 then lanes 0 and 3
    add(1, 0, 5'b10000, 5'b10000, 5'b00000, 0, 13'h0A5);
    add(1, 0, 5'b01001, 5'b00001, 5'b00000, 1, 13'h144);
    add(1, 0, 5'b01000, 5'b01000, 5'b10000, 1, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00001, 1, 13'h133);
    add(1, 0, 5'b00000, 5'b00000, 5'b01000, 1, 13'h133);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h133);
    // stall with lane 1 re-requesting
    add(1, 0, 5'b00010, 5'b00010, 5'b00000, 0, 13'h133);
    add(1, 1, 5'b00010, 5'b00000, 5'b00000, 1, 13'h111);
    add(1, 1, 5'b00010, 5'b00000, 5'b00010, 1, 13'h111);
    add(1, 1, 5'b00010, 5'b00000, 5'b00000, 0, 13'h111);
    add(1, 1, 5'b00010, 5'b00000, 5'b00000, 0, 13'h111);
    add(1, 0, 5'b00010, 5'b00010, 5'b00000, 0, 13'h111);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 13'h111);
    add(1, 0, 5'b00000, 5'b00000, 5'b00010, 1, 13'h111);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h111);
    // stall rising together with requests
    add(1, 1, 5'b11111, 5'b00000, 5'b00000, 0, 13'h111);
    // reset one edge after accepting lane 3
    add(1, 0, 5'b01000, 5'b01000, 5'b00000, 0, 13'h111);
    add(0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 13'h133);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h000);
    add(1, 0, 5'b11001, 5'b00001, 5'b00000, 0, 13'h000);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00001, 1, 13'h100);
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 13'h100);

    // Hand sequence: reset held for three edges with every lane requesting.
    Reset_n = 1'b0;
    stall   = 1'b0;
    req     = '1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    check("reset grant",     32'(grant),     32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset busy",      32'(busy),      32'h0);
    check("reset rom_addr",  32'(rom_addr),  32'h0);

    foreach (tbl[i]) begin
      @(negedge Clk);
      Reset_n = tbl[i].rst_n;
      stall   = tbl[i].stall;
      req     = tbl[i].req;
      #1;
      check($sformatf("row%0d grant", i),     32'(grant),     32'(tbl[i].grant));
      check($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
      check($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].busy));
      check($sformatf("row%0d rom_addr", i),  32'(rom_addr),  32'(tbl[i].ra));
      for (int l = 0; l < N; l++) begin
        if (tbl[i].rv[l])
          check($sformatf("row%0d rsp_data lane%0d", i, l), 32'(rsp_data), 32'(rom_f(lane_addr[l])));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
